// File: rtl/tx_word_arbiter_if.sv
// Bundle between the two word producers, the arbiter and the UART TX byte handshake.
// The slave modport is the arbiter's view; master is the producers/TX side.
interface tx_word_arbiter_if #(
    parameter int WORD_BYTES = 2
);
    logic                    req0_valid;
    logic [8*WORD_BYTES-1:0] req0_data;
    logic                    req0_ready;
    logic                    req1_valid;
    logic [8*WORD_BYTES-1:0] req1_data;
    logic                    req1_ready;
    logic [7:0]              tx_data;
    logic                    tx_start;
    logic                    tx_done;
    logic                    busy;
    logic                    grant;
    logic                    err_timeout;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_done,
        input  req0_ready, req1_ready, tx_data, tx_start, busy, grant, err_timeout
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_done,
        output req0_ready, req1_ready, tx_data, tx_start, busy, grant, err_timeout
    );
endinterface

// File: rtl/tx_word_arbiter.sv
// Round-robin arbiter sharing one UART TX between two word producers; words go out MSB byte first.
// Define TX_ARB_HEADER_EN to prefix every word with header byte 0xA0 | grant.
module tx_word_arbiter #(
    parameter int WORD_BYTES  = 2,
    parameter int ACK_TIMEOUT = 1023
) (
    input logic              clk,
    input logic              rst,
    tx_word_arbiter_if.slave bus
);
`ifdef TX_ARB_HEADER_EN
    localparam int HDR_BYTES = 1;
`else
    localparam int HDR_BYTES = 0;
`endif
    localparam int WORD_W  = 8 * WORD_BYTES;
    localparam int SHIFT_W = 8 * (WORD_BYTES + HDR_BYTES);
    localparam int CNT_W   = $clog2(WORD_BYTES + HDR_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_WAIT
`ifdef TX_ARB_HEADER_EN
        , S_HDR
`endif
    } state_t;

`ifdef TX_ARB_HEADER_EN
    localparam state_t S_FIRST = S_HDR;
`else
    localparam state_t S_FIRST = S_START;
`endif

    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, load_word;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [15:0]        ack_cnt_q;
    logic               grant_q, last_grant_q;
    logic               win_valid, win_id, accept, tx_start, timeout;
    logic [WORD_W-1:0]  win_data;

    always_comb begin
        win_valid = bus.req0_valid | bus.req1_valid;
        // On a tie the producer that did not win last time goes next.
        win_id    = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
        win_data  = win_id ? bus.req1_data : bus.req0_data;
`ifdef TX_ARB_HEADER_EN
        load_word = {8'hA0 | {7'b0, win_id}, win_data};
`else
        load_word = win_data;
`endif
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        tx_start = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_valid && !rst) begin
                    accept  = 1'b1;
                    state_d = S_FIRST;
                end
            end
`ifdef TX_ARB_HEADER_EN
            S_HDR,
`endif
            S_START: begin
                tx_start = 1'b1;
                state_d  = S_ACK;
            end
            S_ACK: begin
                tx_start = 1'b1;
                if (!bus.tx_done) begin
                    state_d = S_WAIT;
                end else if (ack_cnt_q == 16'(ACK_TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.tx_done) begin
                    state_d = (byte_cnt_q == CNT_W'(1)) ? S_IDLE : S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            ack_cnt_q    <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                shift_q      <= load_word;
                byte_cnt_q   <= CNT_W'(WORD_BYTES + HDR_BYTES);
                grant_q      <= win_id;
                last_grant_q <= win_id;
            end else if (state_q == S_WAIT && bus.tx_done && byte_cnt_q != CNT_W'(1)) begin
                shift_q    <= shift_q << 8;
                byte_cnt_q <= byte_cnt_q - CNT_W'(1);
            end
            // Holds 1 outside ACK, so the first ACK cycle of every byte counts as 1.
            ack_cnt_q <= (state_q == S_ACK) ? ack_cnt_q + 16'd1 : 16'd1;
        end
    end

    assign bus.req0_ready  = accept & ~win_id;
    assign bus.req1_ready  = accept & win_id;
    assign bus.tx_start    = tx_start;
    assign bus.tx_data     = shift_q[SHIFT_W-1 -: 8];
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.grant       = grant_q;
    assign bus.err_timeout = timeout;
endmodule

// File: tb/tb_tx_word_arbiter.sv
// Bench for tx_word_arbiter: random producers and a TX model; a scoreboard predicts grants and byte order.
module tb_tx_word_arbiter;
    localparam int WB = 2;
    localparam int WW = 8 * WB;
    localparam int T  = 8;

    typedef struct {
        logic [7:0] b;
        logic       last;
        logic       id;
    } exp_t;

    logic clk, rst;
    logic          pv[2];
    logic [WW-1:0] pd[2];
    logic          en[2];
    logic [WW-1:0] fdata[2];
    bit tie_mode, fixed_data, fixed_tx, stuck;

    int unsigned n_tests = 0, n_fail = 0;
    int   acc_cnt = 0;
    bit   in_flight, last_g, prev_start, exp_start, waiting, saw_low, cur_to, cur_last;
    logic [7:0] cur_byte;
    int   hi_cnt;
    exp_t exp_q[$];

    tx_word_arbiter_if #(.WORD_BYTES(WB)) bus ();

    tx_word_arbiter #(.WORD_BYTES(WB), .ACK_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.req0_valid = pv[0];
    assign bus.req0_data  = pd[0];
    assign bus.req1_valid = pv[1];
    assign bus.req1_data  = pd[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic producer(input int id);
        logic rdy;
        pv[id] = 1'b0;
        pd[id] = '0;
        forever begin
            @(negedge clk);
            rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
            @(posedge clk);
            #1;
            if (!en[id]) begin
                pv[id] = 1'b0;
            end else if (!pv[id] || rdy) begin
                if (tie_mode || fixed_data || $urandom_range(0, 2) == 0) begin
                    pv[id] = 1'b1;
                    pd[id] = (tie_mode || fixed_data) ? fdata[id] : WW'($urandom);
                end else begin
                    pv[id] = 1'b0;
                end
            end else if ($urandom_range(0, 19) == 0 && !tie_mode && !fixed_data) begin
                pv[id] = 1'b0;  // withdraw before being granted
            end
        end
    endtask

    initial producer(0);
    initial producer(1);

    // TX module model: responds only to a fresh start while idle and not stuck.
    initial begin : tx_model
        logic ps;
        int d, l;
        ps = 1'b0;
        bus.tx_done = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.tx_start && !ps && bus.tx_done && !stuck) begin
                d = fixed_tx ? 3 : int'($urandom_range(1, 5));
                l = fixed_tx ? 20 : int'($urandom_range(3, 12));
                repeat (d) @(posedge clk);
                #1 bus.tx_done = 1'b0;
                repeat (l) @(posedge clk);
                #1 bus.tx_done = 1'b1;
            end else begin
                ps = bus.tx_start;
            end
        end
    end

    // Scoreboard: predicts arbitration, busy, byte order and timeout from the rules.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic w, er0, er1, e_err;
        logic [WW-1:0] word;
        if (rst) begin
            in_flight = 0; last_g = 1; prev_start = 0; exp_start = 0;
            waiting = 0; saw_low = 0; hi_cnt = 0; cur_to = 0;
            exp_q.delete();
        end else begin
            check("busy", bus.busy, in_flight);
            w = 1'b0; er0 = 1'b0; er1 = 1'b0;
            if (!in_flight && (pv[0] || pv[1])) begin
                w   = (pv[0] && pv[1]) ? !last_g : pv[1];
                er0 = !w;
                er1 = w;
            end
            check("ready0", bus.req0_ready, er0);
            check("ready1", bus.req1_ready, er1);
            if (exp_start) check("start_latency", bus.tx_start, 1);
            if (saw_low)   check("start_fall", bus.tx_start, 0);
            exp_start = 0;
            saw_low   = 0;
            e_err     = 0;
            if (bus.tx_start) begin
                if (!prev_start) begin
                    check("byte_available", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("tx_byte", bus.tx_data, e.b);
                        check("grant", bus.grant, e.id);
                        cur_byte = e.b;
                        cur_last = e.last;
                    end
                    cur_to  = stuck;
                    hi_cnt  = 1;
                    waiting = 0;
                end else begin
                    hi_cnt++;
                    check("tx_hold", bus.tx_data, cur_byte);
                    if (!bus.tx_done) saw_low = 1;
                end
                e_err = cur_to && hi_cnt == T + 1;
                if (hi_cnt > T + 1) check("start_len", hi_cnt, T + 1);
            end else begin
                if (prev_start && !cur_to) waiting = 1;
                if (waiting) begin
                    check("tx_wait_hold", bus.tx_data, cur_byte);
                    if (bus.tx_done) begin
                        waiting = 0;
                        if (cur_last) in_flight = 0;
                        else exp_start = 1;
                    end
                end
            end
            check("err_timeout", bus.err_timeout, e_err);
            if (e_err) begin
                in_flight = 0;
                if (!cur_last) begin
                    while (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        if (e.last) break;
                    end
                end
            end
            if (er0 || er1) begin
                word = pd[w];
`ifdef TX_ARB_HEADER_EN
                exp_q.push_back('{8'hA0 | {7'b0, w}, 1'b0, w});
`endif
                for (int i = WB - 1; i >= 0; i--) exp_q.push_back('{word[i*8 +: 8], i == 0, w});
                in_flight = 1;
                last_g    = w;
                exp_start = 1;
                acc_cnt++;
            end
            prev_start = bus.tx_start;
        end
    end

    task automatic wait_acc(input int n, input int budget);
        for (int i = 0; i < budget && acc_cnt < n; i++) @(negedge clk);
        check("accept_wait", acc_cnt >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (in_flight || exp_q.size() != 0 || !bus.tx_done); i++)
            @(negedge clk);
        check("idle_wait", !in_flight && exp_q.size() == 0 && bus.tx_done, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

    initial begin : stimulus
        int st;
        rst = 1'b1;
        en[0] = 0; en[1] = 0;
        fdata[0] = '0; fdata[1] = '0;
        tie_mode = 0; fixed_data = 0; fixed_tx = 0; stuck = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_err", bus.err_timeout, 0);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        step();
        rst = 1'b0;

        // Directed single words, fixed TX timing.
        fixed_data = 1; fixed_tx = 1;
        fdata[0] = 16'h12AB; fdata[1] = 16'hBEEF;
        en[0] = 1;
        wait_acc(1, 50);
        step();
        en[0] = 0;
        wait_idle(300);
        check("grant_hold0", bus.grant, 0);
        step();
        en[1] = 1;
        wait_acc(2, 50);
        step();
        en[1] = 0;
        wait_idle(300);
        check("grant_hold1", bus.grant, 1);

        // Continuous tie: strict alternation.
        step();
        fixed_tx = 0; fixed_data = 0; tie_mode = 1;
        fdata[0] = 16'h1111; fdata[1] = 16'h2222;
        en[0] = 1; en[1] = 1;
        wait_acc(acc_cnt + 6, 2000);
        step();
        en[0] = 0; en[1] = 0; tie_mode = 0;
        wait_idle(300);

        // Random traffic, then a stuck TX to force timeouts, then recovery.
        step();
        en[0] = 1; en[1] = 1;
        repeat (3000) @(posedge clk);
        #2 stuck = 1;
        repeat (300) @(posedge clk);
        #2 stuck = 0;
        repeat (500) @(posedge clk);
        #2 en[0] = 0; en[1] = 0;
        wait_idle(500);

        // Reset while the first byte is in WAIT.
        step();
        fixed_data = 1; fixed_tx = 1; fdata[0] = 16'h12AB;
        en[0] = 1;
        st = 0;
        for (int i = 0; i < 200 && st < 2; i++) begin
            @(negedge clk);
            if (st == 0 && bus.tx_start) st = 1;
            else if (st == 1 && !bus.tx_start) st = 2;
        end
        check("reset_setup", st, 2);
        step();
        rst = 1'b1; en[0] = 0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_start", bus.tx_start, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_tx_data", bus.tx_data, 0);
        check("mid_rst_grant", bus.grant, 0);

        // Tie right after reset must go to producer 0 first.
        step();
        fixed_data = 0; tie_mode = 1;
        fdata[0] = 16'h1111; fdata[1] = 16'h2222;
        en[0] = 1; en[1] = 1;
        wait_acc(acc_cnt + 3, 2000);
        step();
        en[0] = 0; en[1] = 0; tie_mode = 0;
        wait_idle(500);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_word_arbiter.md
# tx_word_arbiter

Shares the single UART transmitter between two 16-bit word producers (accumulator dump path and debug/trace path). Arbitrates round-robin, captures the winning word, and serializes it MSB-byte first onto the TX byte interface using the `tx_start`/`tx_done` handshake. Sits between the producers and the TX module, replacing per-producer ad-hoc send logic.

## Interface

**Parameters**
- `WORD_BYTES`, default 2: bytes per word. Word width is `8*WORD_BYTES`.
- `ACK_TIMEOUT`, default 1023: maximum cycles `tx_start` is held waiting for `tx_done` to fall. Range 1..65535.

**Ports**
- `clk` input 1: single clock.
- `rst` input 1: reset, synchronous and active-high.
- `req0_valid` input 1: producer 0 has a word.
- `req0_data` input 8*WORD_BYTES: producer 0 word; held stable while `req0_valid` is high and `req0_ready` is low.
- `req0_ready` output 1: one-cycle accept pulse to producer 0.
- `req1_valid`, `req1_data`, `req1_ready`: same as producer 0, for producer 1.
- `tx_data` output 8: byte to the TX module.
- `tx_start` output 1: transmit request to the TX module.
- `tx_done` input 1: TX idle flag, high while idle; falls after a start is taken; rises when the frame ends.
- `busy` output 1: high from accept until the last byte completes.
- `grant` output 1: ID of the word in flight; holds its last value when idle.
- `err_timeout` output 1: one-cycle pulse when a word is aborted by timeout.

## Operation

**Reset values (all outputs):** 0, including `tx_data`, `tx_start`, both `ready` outputs, `busy`, `grant` and `err_timeout`. The internal `last_grant` register resets to 1, so producer 0 wins the first tie.

**Arbitration (IDLE only)**
- Only one valid: that producer wins.
- Both valid: the producer ≠ `last_grant` wins.
- On the winning cycle: pulse `readyN`, capture `reqN_data` into the shift register, set `grant`=`last_grant`=N, load the byte counter with WORD_BYTES, and go to START (or HDR with the macro enabled).

**States**
- IDLE: as above.
- START: `tx_start`=1, `tx_data`=shift[MSB byte]. Go to ACK.
- ACK: hold `tx_start`=1 and `tx_data`.
  - `tx_done`==0: drop `tx_start` and go to WAIT.
  - Else, if the ack counter reaches ACK_TIMEOUT: drop `tx_start`, pulse `err_timeout`, discard the rest of the word, go to IDLE.
- WAIT: `tx_start`=0, `tx_data` held.
  - On `tx_done`==1: decrement the counter.
  - Counter nonzero: shift left by 8 and go to START.
  - Counter zero: go to IDLE.
- HDR (macro only): same handshake as START/ACK/WAIT with `tx_data`=header byte, then go to START for the first data byte.

**Rules**
- `busy`=1 in every state except IDLE.
- The ack counter restarts at every START.
- `tx_done` is never sampled in IDLE or START.
- A producer dropping `valid` before `ready` is legal; it is simply not granted.
- `valid` is ignored outside IDLE.
- Reset mid-word: on the next edge all outputs return to their reset values and the partial word is lost; producers re-present.

## Timing

- Accept at edge E0 (`readyN` high in cycle 0). `tx_start` rises in cycle 1 with the first byte valid in the same cycle.
- `tx_start` falls the cycle after `tx_done` is first seen low.
- The next byte's `tx_start` rises the cycle after `tx_done` is seen high.
- After the last byte there is one IDLE cycle before the next accept. Minimum gap between `ready` pulses = TX frame time + 2 cycles per byte.
- Timeout: `err_timeout` pulses in the cycle the count reaches ACK_TIMEOUT; `tx_start` is low in the following cycle.

## Configuration

- `TX_ARB_HEADER_EN` defined: each word is preceded by a header byte 0xA0 | {7'b0, grant}, i.e. 0xA0 or 0xA1. This adds one byte to every word, and the timeout abort also covers the header.
- Undefined: no HDR state; only the WORD_BYTES data bytes are sent.

## Test plan

- **Single word:** `req0_valid`, data 0x12AB; TX model drops `tx_done` 3 cycles after start and raises it 20 cycles later. Expect bytes 0x12 then 0xAB, `req0_ready` for exactly one cycle, `busy` low after the second `tx_done` rise, `grant`=0.
- **Tie round-robin:** both valid continuously with 0x1111 and 0x2222. Expect byte order 11 11 22 22 11 11, alternating `grant` 0,1,0, and no extra `ready` pulses.
- **Timeout:** `tx_done` stuck high, ACK_TIMEOUT=8. Expect `tx_start` high for 9 cycles, one `err_timeout` pulse, return to IDLE, and the next request served normally.
- **Reset mid-word:** `rst` asserted during WAIT of byte 1. Next cycle expect `tx_start`=0, `busy`=0, `tx_data`=0; the first grant after reset goes to producer 0 on a tie.
- **Header enabled:** `req1_valid` with data 0xBEEF and the macro defined. Expect byte sequence 0xA1, 0xBE, 0xEF.
- **Late ack:** `tx_done` falls 2 cycles after `tx_start` rises. Expect `tx_start` held exactly until the cycle after the fall and `tx_data` stable throughout.
